// File: rtl/pcap_pkg.sv
// rtl/pcap_pkg.sv - shared pcap constants, state encoding and helpers
package pcap_pkg;

    localparam logic [31:0] PCAP_MAGIC_NS = 32'hA1B23C4D;
    localparam logic [15:0] PCAP_VER_MAJ  = 16'd2;
    localparam logic [15:0] PCAP_VER_MIN  = 16'd4;
    localparam int          GHDR_WORDS    = 3;
    localparam int          RHDR_WORDS    = 2;

    typedef enum logic [2:0] {GHDR, CAPTURE, HDR0, HDR1, DATA} state_t;

    // Number of set bits in a byte-enable vector.
    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

endpackage

// File: rtl/pcap_timestamp.sv
// rtl/pcap_timestamp.sv - free-running ps-exact time split into seconds and nanoseconds
module pcap_timestamp #(
    parameter int unsigned PS_PER_CYCLE = 6400
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] ts_sec,
    output logic [31:0] ts_nsec
);

    localparam int unsigned NS_STEP    = PS_PER_CYCLE / 1000;
    localparam int unsigned PS_STEP    = PS_PER_CYCLE % 1000;
    localparam logic [31:0] NS_PER_SEC = 32'd1_000_000_000;

    logic [9:0]  ps_frac;
    logic [10:0] frac_sum;
    logic        carry;
    logic [31:0] ns_sum;

    // Sub-ns remainder is kept separately so no picoseconds are ever lost.
    always_comb begin
        frac_sum = {1'b0, ps_frac} + 11'(PS_STEP);
        carry    = (frac_sum >= 11'd1000);
        ns_sum   = ts_nsec + 32'(NS_STEP) + {31'd0, carry};
    end

    // Advance one clock period per cycle, wrapping nanoseconds into seconds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_frac <= '0;
            ts_nsec <= '0;
            ts_sec  <= '0;
        end else begin
            ps_frac <= carry ? 10'(frac_sum - 11'd1000) : frac_sum[9:0];
            if (ns_sum >= NS_PER_SEC) begin
                ts_nsec <= ns_sum - NS_PER_SEC;
                ts_sec  <= ts_sec + 32'd1;
            end else begin
                ts_nsec <= ns_sum;
            end
        end
    end

endmodule

// File: rtl/pcap_capture.sv
// rtl/pcap_capture.sv - packet sink that re-emits captured packets as a pcap record stream
module pcap_capture
    import pcap_pkg::*;
#(
    parameter int unsigned MAX_PKT_BYTES   = 2048,
    parameter int unsigned PS_PER_CYCLE    = 6400,
    parameter int unsigned EMIT_GLOBAL_HDR = 1,
    parameter int unsigned LINKTYPE        = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [63:0] in_data,
    input  logic [7:0]  in_strb,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sop,
    input  logic        in_eop,
    output logic [63:0] out_data,
    output logic [7:0]  out_strb,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sop,
    output logic        out_eop,
    output logic [31:0] pktcount,
    output logic [15:0] errcount
);

    localparam int          AW    = $clog2(MAX_PKT_BYTES);
    localparam int          WI    = $clog2(MAX_PKT_BYTES / 8) + 1;
    localparam logic [31:0] MAX32 = 32'(MAX_PKT_BYTES);

    state_t        state;
    logic          pkt_open;
    logic [31:0]   orig_len;
    logic [31:0]   ts_sec_l;
    logic [31:0]   ts_nsec_l;
    logic [WI-1:0] word_idx;
    logic [31:0]   ts_sec;
    logic [31:0]   ts_nsec;
    logic [7:0]    buf_mem [MAX_PKT_BYTES];

    logic          beat;
    logic [3:0]    cnt;
    logic [7:0]    pk [8];
    logic [2:0]    pos;
    logic          noncontig;
    logic          seq_err;
    logic [1:0]    err_inc;
    logic [16:0]   err_sum;
    logic          wr_en;
    logic [31:0]   wr_base;
    logic [31:0]   incl_len;
    logic [31:0]   data_words;
    logic [WI-1:0] rd_idx;
    logic [63:0]   rd_word;
    logic [7:0]    rd_strb;
    logic          rd_last;

    pcap_timestamp #(.PS_PER_CYCLE(PS_PER_CYCLE)) u_ts (
        .clk     (clk),
        .rst_n   (rst_n),
        .ts_sec  (ts_sec),
        .ts_nsec (ts_nsec)
    );

    function automatic logic [63:0] ghdr_word(input logic [1:0] i);
        case (i)
            2'd0:    ghdr_word = {PCAP_VER_MIN, PCAP_VER_MAJ, PCAP_MAGIC_NS};
            2'd2:    ghdr_word = {32'(LINKTYPE), MAX32};
            default: ghdr_word = 64'd0;
        endcase
    endfunction

    // Beat classification, error accounting and contiguous packing of enabled bytes.
    always_comb begin
        beat      = in_valid && in_ready;
        cnt       = popcount8(in_strb);
        noncontig = ((in_strb + 8'd1) & in_strb) != 8'd0;
        seq_err   = in_sop ? pkt_open : !pkt_open;
        err_inc   = {1'b0, noncontig} + {1'b0, seq_err};
        err_sum   = {1'b0, errcount} + 17'(err_inc);
        wr_en     = beat && (in_sop || pkt_open);
        wr_base   = in_sop ? 32'd0 : orig_len;
        pos       = '0;
        for (int k = 0; k < 8; k++) pk[k] = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (in_strb[k]) begin
                pk[pos] = in_data[8*k +: 8];
                pos     = pos + 3'd1;
            end
        end
    end

    // Packet buffer: bytes past the snaplen are silently dropped.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int j = 0; j < 8; j++) begin
                if ((4'(j) < cnt) && ((wr_base + 32'(j)) < MAX32))
                    buf_mem[AW'(wr_base + 32'(j))] <= pk[j];
            end
        end
    end

    // Next DATA word: read from the buffer, zero bytes beyond incl_len.
    always_comb begin
        incl_len   = (orig_len > MAX32) ? MAX32 : orig_len;
        data_words = (incl_len + 32'd7) >> 3;
        rd_idx     = (state == DATA) ? word_idx : '0;
        rd_word    = '0;
        for (int j = 0; j < 8; j++) begin
            if ((32'(rd_idx) * 32'd8 + 32'(j)) < incl_len)
                rd_word[8*j +: 8] = buf_mem[AW'(32'(rd_idx) * 32'd8 + 32'(j))];
        end
        rd_last = ((32'(rd_idx) + 32'd1) == data_words);
        rd_strb = 8'hFF;
        if (rd_last && (incl_len[2:0] != 3'd0))
            rd_strb = 8'hFF >> (4'd8 - {1'b0, incl_len[2:0]});
    end

    // Capture/emit sequencer; every output word is loaded here and held until taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= (EMIT_GLOBAL_HDR != 0) ? GHDR : CAPTURE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_sop   <= 1'b0;
            out_eop   <= 1'b0;
            out_data  <= '0;
            out_strb  <= '0;
            pktcount  <= '0;
            errcount  <= '0;
            pkt_open  <= 1'b0;
            orig_len  <= '0;
            ts_sec_l  <= '0;
            ts_nsec_l <= '0;
            word_idx  <= '0;
        end else begin
            case (state)
                GHDR: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                        out_data  <= ghdr_word(2'd0);
                        out_strb  <= 8'hFF;
                        out_sop   <= 1'b1;
                        out_eop   <= 1'b0;
                        word_idx  <= WI'(1);
                    end else if (out_ready) begin
                        if (out_eop) begin
                            out_valid <= 1'b0;
                            out_sop   <= 1'b0;
                            out_eop   <= 1'b0;
                            in_ready  <= 1'b1;
                            state     <= CAPTURE;
                        end else begin
                            out_data <= ghdr_word(word_idx[1:0]);
                            out_sop  <= 1'b0;
                            out_eop  <= (word_idx == WI'(GHDR_WORDS - 1));
                            word_idx <= word_idx + WI'(1);
                        end
                    end
                end
                CAPTURE: begin
                    in_ready <= 1'b1;
                    if (beat) begin
                        errcount <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
                        if (in_sop) begin
                            orig_len  <= 32'(cnt);
                            ts_sec_l  <= ts_sec;
                            ts_nsec_l <= ts_nsec;
                            pkt_open  <= 1'b1;
                        end else if (pkt_open) begin
                            orig_len <= orig_len + 32'(cnt);
                        end
                        if (in_eop && (in_sop || pkt_open)) begin
                            in_ready  <= 1'b0;
                            pkt_open  <= 1'b0;
                            state     <= HDR0;
                            out_valid <= 1'b1;
                            out_sop   <= 1'b1;
                            out_eop   <= 1'b0;
                            out_strb  <= 8'hFF;
                            out_data  <= in_sop ? {ts_nsec, ts_sec} : {ts_nsec_l, ts_sec_l};
                        end
                    end
                end
                HDR0: begin
                    if (out_ready) begin
                        out_data <= {orig_len, incl_len};
                        out_sop  <= 1'b0;
                        out_eop  <= (incl_len == 32'd0);
                        state    <= HDR1;
                    end
                end
                HDR1, DATA: begin
                    if (out_ready) begin
                        if (out_eop) begin
                            out_valid <= 1'b0;
                            out_sop   <= 1'b0;
                            out_eop   <= 1'b0;
                            pktcount  <= pktcount + 32'd1;
                            in_ready  <= 1'b1;
                            state     <= CAPTURE;
                        end else begin
                            out_data <= rd_word;
                            out_strb <= rd_strb;
                            out_eop  <= rd_last;
                            word_idx <= rd_idx + WI'(1);
                            state    <= DATA;
                        end
                    end
                end
                default: state <= CAPTURE;
            endcase
        end
    end

endmodule

// File: tb/tb_pcap_capture.sv
// tb/tb_pcap_capture.sv - directed self-checking bench for pcap_capture
module tb_pcap_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [63:0] in_data;
    logic [7:0]  in_strb;
    logic        in_valid;
    logic        in_ready;
    logic        in_sop;
    logic        in_eop;
    logic [63:0] out_data;
    logic [7:0]  out_strb;
    logic        out_valid;
    logic        out_ready;
    logic        out_sop;
    logic        out_eop;
    logic [31:0] pktcount;
    logic [15:0] errcount;

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    logic        stall_pend = 1'b0;
    logic [73:0] stall_word;
    logic        ir_high;
    logic [73:0] w;

    pcap_capture #(
        .MAX_PKT_BYTES   (2048),
        .PS_PER_CYCLE    (6400),
        .EMIT_GLOBAL_HDR (1),
        .LINKTYPE        (1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_strb   (in_strb),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sop    (in_sop),
        .in_eop    (in_eop),
        .out_data  (out_data),
        .out_strb  (out_strb),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .pktcount  (pktcount),
        .errcount  (errcount)
    );

    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pbyte(input int i, input int seed);
        int v;
        v = i * 13 + seed * 31 + 1;
        return v[7:0];
    endfunction

    task automatic send_beat(input logic [63:0] d, input logic [7:0] s, input logic sop, input logic eop);
        int n;
        n = 0;
        in_data  = d;
        in_strb  = s;
        in_sop   = sop;
        in_eop   = eop;
        in_valid = 1'b1;
        while (in_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_wait", 128'(in_ready), 128'(1));
        @(negedge clk);
    endtask

    task automatic send_packet(input int seed, input int nbytes, input bit first_sop, input bit last_eop);
        int nb;
        int rem;
        logic [63:0] d;
        logic [7:0] s;
        nb = (nbytes + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            rem = nbytes - b * 8;
            d = {8{8'hEE}};
            s = 8'h00;
            for (int j = 0; j < 8; j++) begin
                if (j < rem) begin
                    d[8*j +: 8] = pbyte(b * 8 + j, seed);
                    s[j] = 1'b1;
                end
            end
            send_beat(d, s, first_sop && (b == 0), last_eop && (b == nb - 1));
        end
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
    endtask

    // Returns {sop, eop, strb, data}; exits at the negedge after the transfer.
    task automatic read_word(input bit rnd, output logic [73:0] wo);
        int n;
        bit got;
        n = 0;
        got = 0;
        wo = '0;
        while (!got && n < 5000) begin
            if (stall_pend)
                chk("stall_hold", {out_valid, out_sop, out_eop, out_strb, out_data}, {1'b1, stall_word});
            if (rnd) out_ready = 1'($urandom_range(0, 1));
            if (in_ready) ir_high = 1'b1;
            stall_pend = out_valid && !out_ready;
            stall_word = {out_sop, out_eop, out_strb, out_data};
            if (out_valid && out_ready) begin
                wo = {out_sop, out_eop, out_strb, out_data};
                got = 1;
            end else begin
                @(negedge clk);
                n++;
            end
        end
        chk("word_timeout", 128'(got), 128'(1));
        @(negedge clk);
    endtask

    task automatic expect_record(input string tag, input int seed, input int orig, input bit chk_ts,
                                 input logic [31:0] nsec, input bit rnd);
        int incl;
        int nw;
        int rem;
        logic [73:0] r;
        logic [63:0] d;
        logic [7:0] s;
        incl = (orig > 2048) ? 2048 : orig;
        nw = (incl + 7) / 8;
        read_word(rnd, r);
        chk({tag, "_hdr0_flags"}, r[73:64], {1'b1, 1'b0, 8'hFF});
        if (chk_ts) chk({tag, "_hdr0_ts"}, r[63:0], {nsec, 32'd0});
        read_word(rnd, r);
        chk({tag, "_hdr1"}, r, {1'b0, incl == 0, 8'hFF, 32'(orig), 32'(incl)});
        for (int i = 0; i < nw; i++) begin
            d = '0;
            for (int j = 0; j < 8; j++)
                if (i * 8 + j < incl) d[8*j +: 8] = pbyte(i * 8 + j, seed);
            rem = incl - i * 8;
            s = (rem >= 8) ? 8'hFF : 8'((1 << rem) - 1);
            read_word(rnd, r);
            chk({tag, "_data"}, r, {1'b0, i == nw - 1, s, d});
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_data   = '0;
        in_strb   = '0;
        in_valid  = 1'b0;
        in_sop    = 1'b0;
        in_eop    = 1'b0;
        out_ready = 1'b1;
        ir_high   = 1'b0;
        repeat (3) @(negedge clk);

        // 1: reset values, then the global header
        chk("rst_in_ready", 128'(in_ready), 128'(0));
        chk("rst_out_flags", {out_valid, out_sop, out_eop, out_strb}, 128'(0));
        chk("rst_out_data", out_data, 128'(0));
        chk("rst_counts", {pktcount, errcount}, 128'(0));
        rst_n = 1'b1;
        read_word(0, w);
        chk("ghdr_w0", w, {1'b1, 1'b0, 8'hFF, 64'h0004_0002_A1B2_3C4D});
        read_word(0, w);
        chk("ghdr_w1", w, {1'b0, 1'b0, 8'hFF, 64'h0});
        read_word(0, w);
        chk("ghdr_w2", w, {1'b0, 1'b1, 8'hFF, 64'h0000_0001_0000_0800});
        chk("ghdr_pktcount", pktcount, 128'(0));

        // 2: 60-byte packet, sop accepted on cycle 1000
        while (cyc != 1000) @(negedge clk);
        chk("t2_ready_idle", 128'(in_ready), 128'(1));
        send_packet(1, 60, 1, 1);
        chk("t2_latency", {out_valid, in_ready}, {1'b1, 1'b0});
        expect_record("t2", 1, 60, 1, 32'd6400, 0);
        chk("t2_pktcount", pktcount, 128'(1));

        // 3: oversize packet truncated to snaplen
        send_packet(2, 2100, 1, 1);
        ir_high = 1'b0;
        expect_record("t3", 2, 2100, 0, 32'd0, 0);
        chk("t3_in_ready_low", 128'(ir_high), 128'(0));
        chk("t3_in_ready_back", 128'(in_ready), 128'(1));
        chk("t3_pktcount", pktcount, 128'(2));

        // 4: same record as test 2 under random backpressure
        send_packet(1, 60, 1, 1);
        expect_record("t4", 1, 60, 0, 32'd0, 1);
        out_ready = 1'b1;
        chk("t4_pktcount", pktcount, 128'(3));

        // 5: stray beat while idle, then sop while a packet is open
        send_beat({8{8'h55}}, 8'hFF, 1'b0, 1'b0);
        in_valid = 1'b0;
        send_packet(3, 16, 1, 0);
        send_packet(4, 10, 1, 1);
        chk("t5_errcount", errcount, 128'(2));
        expect_record("t5", 4, 10, 0, 32'd0, 0);
        chk("t5_pktcount", pktcount, 128'(4));

        // 6: single-beat packet, asynchronous reset while HDR1 is pending
        send_beat({{7{8'hEE}}, 8'hAB}, 8'h01, 1'b1, 1'b1);
        in_valid = 1'b0;
        in_sop   = 1'b0;
        in_eop   = 1'b0;
        read_word(0, w);
        chk("t6_hdr0_flags", w[73:64], {1'b1, 1'b0, 8'hFF});
        out_ready = 1'b0;
        chk("t6_hdr1", {out_valid, out_data}, {1'b1, 64'h0000_0001_0000_0001});
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_valid", {out_valid, out_sop, out_eop, in_ready}, 128'(0));
        chk("t6_async_data", {out_data, out_strb}, 128'(0));
        chk("t6_async_counts", {pktcount, errcount}, 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        read_word(0, w);
        chk("t6_ghdr_w0", w, {1'b1, 1'b0, 8'hFF, 64'h0004_0002_A1B2_3C4D});
        read_word(0, w);
        chk("t6_ghdr_w1", w, {1'b0, 1'b0, 8'hFF, 64'h0});
        read_word(0, w);
        chk("t6_ghdr_w2", w, {1'b0, 1'b1, 8'hFF, 64'h0000_0001_0000_0800});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pcap_capture.md
Name: pcap_capture

Overview:
- Receive-side counterpart of the pcap replay source: a sink on the 64-bit packet stream.
- Stores each received packet whole, then re-emits it as a byte-exact little-endian, nanosecond-precision pcap record stream: an optional global header, then per packet a 16-byte record header followed by the packet bytes.
- Downstream is a file-dump model or a DMA; upstream is the DUT's output stream.

Parameters:
- MAX_PKT_BYTES, 2048, buffer size and pcap snaplen; multiple of 8, at least 64.
- PS_PER_CYCLE, 6400, clock period in ps (156.25 MHz); used to advance the timestamp.
- EMIT_GLOBAL_HDR, 1, emit the 24-byte pcap global header once after reset.
- LINKTYPE, 1, network field of the global header (1 = Ethernet).

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- in_data, in, 64, packet bytes; byte k on [8k+7:8k].
- in_strb, in, 8, byte enables; contiguous from bit 0.
- in_valid, in, 1, beat valid.
- in_ready, out, 1, beat accepted when in_valid && in_ready.
- in_sop, in, 1, first beat of a packet.
- in_eop, in, 1, last beat of a packet.
- out_data, out, 64, pcap byte stream; byte k on [8k+7:8k].
- out_strb, out, 8, byte enables of out_data.
- out_valid, out, 1, output beat valid.
- out_ready, in, 1, downstream ready.
- out_sop, out, 1, first word of a record (global header counts as a record).
- out_eop, out, 1, last word of a record.
- pktcount, out, 32, records emitted.
- errcount, out, 16, protocol errors seen; saturating.

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_sop=0, out_eop=0, out_data=0, out_strb=0, pktcount=0, errcount=0, timestamp=0, state=GHDR if EMIT_GLOBAL_HDR else CAPTURE.
- Reset mid-operation: partial or buffered packet lost; global header re-emitted.
- Timestamp: free-running time kept exactly in ps. Each cycle adds PS_PER_CYCLE. Derived ts_nsec (0..999999999) wraps into ts_sec (32 bit). Latched on acceptance of the sop beat.
- Output handshake: a word is held stable (data, strb, sop, eop) until out_valid && out_ready. out_valid is never dropped without a transfer.
- GHDR: three words, all strb=FF; sop on word 0, eop on word 2.
  - Word 0 bytes: 4D 3C B2 A1 02 00 04 00.
  - Word 1 bytes: all 00.
  - Word 2 bytes: MAX_PKT_BYTES as u32 LE, then LINKTYPE as u32 LE.
  - Then go to CAPTURE. The global header does not count in pktcount.
- CAPTURE: in_ready=1.
  - Bytes are appended to the buffer at byte offset len; len += popcount(in_strb).
  - Bytes beyond MAX_PKT_BYTES are dropped, but orig_len keeps counting (32 bit).
  - Accepted beat with in_eop: in_ready=0 next cycle; go to HDR0.
- HDR0: word = ts_sec LE, ts_nsec LE; strb=FF; sop=1.
- HDR1: word = incl_len = min(orig_len, MAX_PKT_BYTES) LE, then orig_len LE; strb=FF.
  - eop=1 if incl_len==0.
- DATA: ceil(incl_len/8) words from the buffer.
  - Last word: strb has (incl_len mod 8, or 8 if 0) low bits set; eop=1.
  - Bytes above strb are 00.
- pktcount increments on the transfer carrying record eop. State then returns to CAPTURE; in_ready=1 the next cycle.
- Latency: first HDR0 out_valid occurs 1 cycle after the eop beat is accepted.
- Errors, each incrementing errcount (saturating at FFFF):
  - Beat with in_sop while a packet is open: previous bytes discarded; the new packet starts with this beat's timestamp.
  - Beat without in_sop while no packet is open: beat dropped.
  - Non-contiguous in_strb: bytes are counted by popcount and packed contiguously.
- Simultaneous sop and eop on one beat: a single-beat packet.
- A beat with strb=00 adds 0 bytes.

Decomposition:
- Shared package pcap_pkg holds:
  - PCAP_MAGIC_NS (32'hA1B23C4D), PCAP_VER_MAJ=2, PCAP_VER_MIN=4, GHDR_WORDS=3, RHDR_WORDS=2.
  - The state enum {GHDR, CAPTURE, HDR0, HDR1, DATA}.
  - A popcount8 function.
- One natural sub-module: pcap_timestamp (ps accumulator producing ts_sec/ts_nsec).
- The buffer is an inferred single-port register array inside pcap_capture.

Test Plan:
1. Reset, out_ready=1, EMIT_GLOBAL_HDR=1 -> three words: 0x0004_0002_A1B2_3C4D, 0x0, 0x0000_0001_0000_0800 (MAX_PKT_BYTES=2048, read little-endian); sop on word 0, eop on word 2; pktcount=0.
2. 60-byte packet as 8 beats (last strb=0F), sop beat accepted at cycle 1000 -> HDR1 = 0x0000_003C_0000_003C; 8 DATA words, last strb=0F, bytes match input; ts_nsec=6400; pktcount=1.
3. 2100-byte packet -> incl_len=2048, orig_len=2100; 256 DATA words, last strb=FF; in_ready held 0 until the eop word transfers.
4. out_ready toggled 1/0 randomly across a record -> output words identical to the stalled-free case; no word dropped or duplicated.
5. sop, 2 beats, then a new sop; plus a stray non-sop beat while idle -> errcount=2; only the second packet is recorded.
6. Single beat with sop=eop=1, strb=01, then rst_n low in the middle of HDR1 -> outputs return to reset values asynchronously; the global header is re-emitted after release.
